// File: rtl/arm_mul_pkg.sv
// Shared types and helpers for the iterative ARM multiply unit.
package arm_mul_pkg;

    // Operation encoding as presented on the op port by the controller.
    typedef enum logic [1:0] {
        MUL_OP   = 2'b00,
        MLA_OP   = 2'b01,
        UMULL_OP = 2'b10,
        SMULL_OP = 2'b11
    } mul_op_t;

    // Control states of the multiplier sequencer.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } mul_state_t;

    // Number of shift-add iterations needed to consume the whole multiplier.
    function automatic int mul_iterations(input int width, input int bits_per_cycle);
        return width / bits_per_cycle;
    endfunction

    // Counter width able to hold the iteration count itself as well as zero.
    function automatic int mul_count_width(input int iterations);
        return $clog2(iterations + 1);
    endfunction

endpackage

// File: rtl/arm_mul_unit_mul_step.sv
// One shift-add iteration: adds multiplicand x low multiplier digit into the
// running high word, then shifts the {carry, high word, multiplier} chain right.
module mul_step
    import arm_mul_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] prod_hi,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] next_prod_hi,
    output logic [WIDTH-1:0] next_mplier
);

    localparam int SW = WIDTH + BITS_PER_CYCLE;

    logic [SW-1:0] mcand_ext;
    logic [SW-1:0] digit_ext;
    logic [SW-1:0] partial;
    logic [SW-1:0] sum;

    // The sum is kept BITS_PER_CYCLE bits wider than a word so the carry out of
    // the partial-product add is shifted into the high word instead of lost.
    always_comb begin
        mcand_ext    = {{BITS_PER_CYCLE{1'b0}}, mcand};
        digit_ext    = {{WIDTH{1'b0}}, mplier[BITS_PER_CYCLE-1:0]};
        partial      = mcand_ext * digit_ext;
        sum          = {{BITS_PER_CYCLE{1'b0}}, prod_hi} + partial;
        next_prod_hi = sum[SW-1:BITS_PER_CYCLE];
        next_mplier  = {sum[BITS_PER_CYCLE-1:0], mplier[WIDTH-1:BITS_PER_CYCLE]};
    end

endmodule

// File: rtl/arm_mul_unit.sv
// Iterative MUL / MLA / UMULL / SMULL execution unit with NZ flag generation.
// The multiplier register doubles as the low product word as it shifts out.
module arm_mul_unit
    import arm_mul_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             s_bit,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [1:0]       flags_nz,
    output logic             flags_we
);

    localparam int ITER = mul_iterations(WIDTH, BITS_PER_CYCLE);
    localparam int CW   = mul_count_width(ITER);
    localparam logic [CW-1:0] ITER_CNT = CW'(ITER);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    mul_state_t state_q;
    mul_state_t next_state;

    mul_op_t          op_in;
    mul_op_t          op_q;
    logic             s_bit_q;
    logic             neg_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] prod_hi_q;
    logic [WIDTH-1:0] acc_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_prod_hi;
    logic [WIDTH-1:0] step_mplier;

    logic [2*WIDTH-1:0] raw_product;
    logic [2*WIDTH-1:0] signed_product;
    logic               is_long;
    logic [WIDTH-1:0]   fin_lo;
    logic [WIDTH-1:0]   fin_hi;
    logic [1:0]         fin_nz;

    assign op_in = mul_op_t'(op);

    // Sign-magnitude conversion for SMULL; the most-negative value maps to
    // 2^(WIDTH-1), which still fits in an unsigned word.
    always_comb begin
        a_mag = a[WIDTH-1] ? ('0 - a) : a;
        b_mag = b[WIDTH-1] ? ('0 - b) : b;
    end

    mul_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .mcand        (mcand_q),
        .prod_hi      (prod_hi_q),
        .mplier       (mplier_q),
        .next_prod_hi (step_prod_hi),
        .next_mplier  (step_mplier)
    );

    // Final result shaping: restore the sign for SMULL, add the accumulator for
    // MLA, and derive N and Z over the width the operation actually produces.
    always_comb begin
        raw_product    = {prod_hi_q, mplier_q};
        signed_product = raw_product;
        if (op_q == SMULL_OP && neg_q) begin
            signed_product = '0 - raw_product;
        end
        is_long = (op_q == UMULL_OP) || (op_q == SMULL_OP);
        fin_lo  = signed_product[WIDTH-1:0];
        if (op_q == MLA_OP) begin
            fin_lo = signed_product[WIDTH-1:0] + acc_q;
        end
        fin_hi = '0;
        if (is_long) begin
            fin_hi = signed_product[2*WIDTH-1:WIDTH];
        end
        if (is_long) begin
            fin_nz = {fin_hi[WIDTH-1], (signed_product == '0)};
        end else begin
            fin_nz = {fin_lo[WIDTH-1], (fin_lo == '0)};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state logic: RUN spends ITER cycles stepping and one more cycle
    // (counter at zero) while the finished product is shaped into the results.
    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    next_state = S_IDLE;
                end else if (count_q == '0) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and registered results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= MUL_OP;
            s_bit_q   <= 1'b0;
            neg_q     <= 1'b0;
            count_q   <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_hi_q <= '0;
            acc_q     <= '0;
            result_lo <= '0;
            result_hi <= '0;
            flags_nz  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q      <= op_in;
                        s_bit_q   <= s_bit;
                        acc_q     <= acc;
                        count_q   <= ITER_CNT;
                        prod_hi_q <= '0;
                        if (op_in == SMULL_OP) begin
                            mcand_q  <= a_mag;
                            mplier_q <= b_mag;
                            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
                        end else begin
                            mcand_q  <= a;
                            mplier_q <= b;
                            neg_q    <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (!cancel) begin
                        if (count_q != '0) begin
                            prod_hi_q <= step_prod_hi;
                            mplier_q  <= step_mplier;
                            count_q   <= count_q - ONE_CNT;
                        end else begin
                            result_lo <= fin_lo;
                            result_hi <= fin_hi;
                            flags_nz  <= fin_nz;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign flags_we = done & s_bit_q;

endmodule
